slurm32_mem_arbiter: RTL and testbench

- Shares the single SLURM32 memory port between the pipeline's instruction fetch and its stage-3 data accesses (load/store).
- Data has priority, because a lost data grant forces a pipeline replay via memory_request_successful=0. A starvation counter guarantees fetch progress.
- Tracks in-order outstanding reads with a small tag FIFO, routes returned data to the correct requester, and discards killed fetches after a flush.

---
 rtl/slurm32_mem_arbiter_pkg.sv | 23 ++
 rtl/slurm32_tag_fifo.sv | 94 +++++++++
 rtl/slurm32_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_slurm32_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slurm32_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slurm32_cpu_defs (package)
// Description : Shared definitions for the SLURM32 memory arbiter: layout of
//               the outstanding-read tag and the grant encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package slurm32_cpu_defs;

    // Tag carried per outstanding read: {kill, is_data}
    localparam int TAG_W       = 2;
    localparam int TAG_IS_DATA = 0;
    localparam int TAG_KILL    = 1;

    // Winner of the memory port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_INSTR = 2'd1,
        GNT_DATA  = 2'd2
    } gnt_t;

endpackage : slurm32_cpu_defs
`default_nettype wire

// File: rtl/slurm32_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : slurm32_tag_fifo
// Description : Small in-order FIFO of outstanding-read tags. A kill_all pulse
//               marks every queued fetch entry (and a fetch pushed in the same
//               cycle) as killed; data entries are left untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module slurm32_tag_fifo #(
    parameter int DEPTH    = 2,
    parameter int WIDTH    = 2,
    parameter int KILL_BIT = 1,
    parameter int DATA_BIT = 0
) (
    input  logic             CLK,
    input  logic             RSTb,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_kill_all,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_push_ok;
    logic               w_pop_ok;
    logic [WIDTH-1:0]   w_push_entry;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // A fetch entering during a flush is born already killed
    always_comb begin
        w_push_entry = i_push_data;
        if (i_kill_all && !i_push_data[DATA_BIT]) begin
            w_push_entry[KILL_BIT] = 1'b1;
        end
    end

    // Tag storage: kill marking of queued fetches, then the new entry
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_all && !r_mem[i][DATA_BIT]) begin
                    r_mem[i][KILL_BIT] <= 1'b1;
                end
            end
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_push_entry;
            end
        end
    end

    // Pointers wrap at DEPTH; occupancy is unchanged on simultaneous push/pop
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : slurm32_tag_fifo
`default_nettype wire

// File: rtl/slurm32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : slurm32_mem_arbiter
// Description : Shares the SLURM32 memory port between instruction fetch and
//               stage-3 data accesses. Data wins unless a fetch has starved
//               for STARVE_LIMIT data grants. Outstanding reads are tracked in
//               order so responses are routed back, and flushed fetches are
//               silently dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module slurm32_mem_arbiter
    import slurm32_cpu_defs::*;
#(
    parameter int BITS            = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,

    input  logic                    instruction_request,
    input  logic [ADDRESS_BITS-1:0] instruction_address,
    output logic                    instruction_valid,
    output logic [BITS-1:0]         instruction_in,
    input  logic                    flush,

    input  logic                    data_request,
    input  logic                    data_wr,
    input  logic [ADDRESS_BITS-1:0] data_address,
    input  logic [BITS-1:0]         data_wdata,
    input  logic [BITS/8-1:0]       data_be,
    output logic                    memory_request_successful,
    output logic                    data_rvalid,
    output logic [BITS-1:0]         data_rdata,

    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_wr,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    output logic [BITS/8-1:0]       mem_be,
    input  logic                    mem_rvalid,
    input  logic [BITS-1:0]         mem_rdata,

    output logic                    protocol_error
);

    localparam int                   c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    gnt_t                   w_gnt;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [TAG_W-1:0]       w_push_tag;
    logic [TAG_W-1:0]       w_head;
    logic                   w_full;
    logic                   w_empty;

    logic [c_STARVE_W-1:0]  r_starve;
    logic                   r_mrs;
    logic                   r_perr;

    // Winner selection: starving fetch first, then data, then fetch
    always_comb begin
        w_gnt = GNT_NONE;
        if (!w_full) begin
            if (instruction_request && (r_starve == c_STARVE_MAX)) begin
                w_gnt = GNT_INSTR;
            end else if (data_request) begin
                w_gnt = GNT_DATA;
            end else if (instruction_request) begin
                w_gnt = GNT_INSTR;
            end
        end
    end

    // Memory request fields follow the winner; fetches are full-word reads
    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (w_gnt)
            GNT_INSTR: begin
                mem_addr = instruction_address;
                mem_be   = '1;
            end
            GNT_DATA: begin
                mem_wr    = data_wr;
                mem_addr  = data_address;
                mem_wdata = data_wdata;
                mem_be    = data_be;
            end
            default: ;
        endcase
    end

    // Valid outputs are forced low while reset is held, as reset is asynchronous
    assign mem_valid = RSTb && (w_gnt != GNT_NONE);
    assign w_accept  = mem_valid && mem_ready;

    // Stores complete without a response, so only reads occupy a tag slot
    assign w_push = w_accept && !((w_gnt == GNT_DATA) && data_wr);
    always_comb begin
        w_push_tag              = '0;
        w_push_tag[TAG_IS_DATA] = (w_gnt == GNT_DATA);
    end

    assign w_pop = mem_rvalid && !w_empty;

    slurm32_tag_fifo #(
        .DEPTH    (MAX_OUTSTANDING),
        .WIDTH    (TAG_W),
        .KILL_BIT (TAG_KILL),
        .DATA_BIT (TAG_IS_DATA)
    ) u_tag_fifo (
        .CLK         (CLK),
        .RSTb        (RSTb),
        .i_push      (w_push),
        .i_push_data (w_push_tag),
        .i_pop       (w_pop),
        .i_kill_all  (flush),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Response routing: a fetch popped during a flush is suppressed as well
    assign data_rvalid       = RSTb && w_pop && w_head[TAG_IS_DATA];
    assign instruction_valid = RSTb && w_pop && !w_head[TAG_IS_DATA]
                               && !w_head[TAG_KILL] && !flush;
    assign data_rdata        = mem_rdata;
    assign instruction_in    = mem_rdata;

    // Starvation counter: counts data wins while a fetch keeps waiting
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_starve <= '0;
        end else if (!instruction_request) begin
            r_starve <= '0;
        end else if (w_accept && (w_gnt == GNT_INSTR)) begin
            r_starve <= '0;
        end else if (w_accept && (w_gnt == GNT_DATA) && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Data acceptance is reported one cycle late; sticky error on orphan response
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_mrs  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_mrs <= w_accept && (w_gnt == GNT_DATA);
            if (mem_rvalid && w_empty) begin
                r_perr <= 1'b1;
            end
        end
    end

    assign memory_request_successful = r_mrs;
    assign protocol_error            = r_perr;

endmodule : slurm32_mem_arbiter
`default_nettype wire

// File: tb/tb_slurm32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_slurm32_mem_arbiter
// Description : Directed self-checking bench for slurm32_mem_arbiter with a
//               queue-based reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slurm32_mem_arbiter;

    localparam int BITS  = 32;
    localparam int AW    = 32;
    localparam int MAXO  = 2;
    localparam int STARV = 4;

    logic            CLK;
    logic            RSTb;
    logic            instruction_request;
    logic [AW-1:0]   instruction_address;
    logic            instruction_valid;
    logic [BITS-1:0] instruction_in;
    logic            flush;
    logic            data_request;
    logic            data_wr;
    logic [AW-1:0]   data_address;
    logic [BITS-1:0] data_wdata;
    logic [3:0]      data_be;
    logic            memory_request_successful;
    logic            data_rvalid;
    logic [BITS-1:0] data_rdata;
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [BITS-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_rvalid;
    logic [BITS-1:0] mem_rdata;
    logic            protocol_error;

    int n_total = 0;
    int n_bad   = 0;

    slurm32_mem_arbiter #(
        .BITS            (BITS),
        .ADDRESS_BITS    (AW),
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (STARV)
    ) dut (
        .CLK                       (CLK),
        .RSTb                      (RSTb),
        .instruction_request       (instruction_request),
        .instruction_address       (instruction_address),
        .instruction_valid         (instruction_valid),
        .instruction_in            (instruction_in),
        .flush                     (flush),
        .data_request              (data_request),
        .data_wr                   (data_wr),
        .data_address              (data_address),
        .data_wdata                (data_wdata),
        .data_be                   (data_be),
        .memory_request_successful (memory_request_successful),
        .data_rvalid               (data_rvalid),
        .data_rdata                (data_rdata),
        .mem_valid                 (mem_valid),
        .mem_ready                 (mem_ready),
        .mem_wr                    (mem_wr),
        .mem_addr                  (mem_addr),
        .mem_wdata                 (mem_wdata),
        .mem_be                    (mem_be),
        .mem_rvalid                (mem_rvalid),
        .mem_rdata                 (mem_rdata),
        .protocol_error            (protocol_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit is_data;
        bit kill;
    } tag_t;

    tag_t q[$];
    int   m_starve = 0;
    bit   m_mrs    = 0;
    bit   m_perr   = 0;

    // Compare at the falling edge; inputs change just after the rising edge
    always @(negedge CLK) begin
        if (!RSTb) begin
            q.delete();
            m_starve = 0;
            m_mrs    = 0;
            m_perr   = 0;
            chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
            chk("rst_ivalid",    {31'd0, instruction_valid}, 32'd0);
            chk("rst_dvalid",    {31'd0, data_rvalid}, 32'd0);
            chk("rst_mrs",       {31'd0, memory_request_successful}, 32'd0);
            chk("rst_perr",      {31'd0, protocol_error}, 32'd0);
        end else begin
            int   g;
            bit   pop, e_dv, e_iv, acc;
            tag_t hd;
            g = 0;
            if (q.size() < MAXO) begin
                if (instruction_request && m_starve >= STARV) g = 1;
                else if (data_request) g = 2;
                else if (instruction_request) g = 1;
            end
            chk("mem_valid", {31'd0, mem_valid}, {31'd0, g != 0});
            if (g == 1) begin
                chk("f_mem_wr",   {31'd0, mem_wr}, 32'd0);
                chk("f_mem_addr", mem_addr, instruction_address);
                chk("f_mem_be",   {28'd0, mem_be}, 32'hF);
            end else if (g == 2) begin
                chk("d_mem_wr",    {31'd0, mem_wr}, {31'd0, data_wr});
                chk("d_mem_addr",  mem_addr, data_address);
                chk("d_mem_wdata", mem_wdata, data_wdata);
                chk("d_mem_be",    {28'd0, mem_be}, {28'd0, data_be});
            end
            pop  = mem_rvalid && (q.size() > 0);
            hd   = pop ? q[0] : '{is_data: 1'b0, kill: 1'b0};
            e_dv = pop && hd.is_data;
            e_iv = pop && !hd.is_data && !hd.kill && !flush;
            chk("data_rvalid", {31'd0, data_rvalid}, {31'd0, e_dv});
            chk("instr_valid", {31'd0, instruction_valid}, {31'd0, e_iv});
            if (e_dv) chk("data_rdata", data_rdata, mem_rdata);
            if (e_iv) chk("instr_in", instruction_in, mem_rdata);
            chk("mrs",  {31'd0, memory_request_successful}, {31'd0, m_mrs});
            chk("perr", {31'd0, protocol_error}, {31'd0, m_perr});

            // advance model to the state after the coming rising edge
            acc   = (g != 0) && mem_ready;
            m_mrs = acc && (g == 2);
            if (mem_rvalid && q.size() == 0) m_perr = 1;
            if (pop) void'(q.pop_front());
            if (flush) foreach (q[i]) if (!q[i].is_data) q[i].kill = 1;
            if (acc && !(g == 2 && data_wr))
                q.push_back('{is_data: (g == 2), kill: (flush && g == 1)});
            if (!instruction_request) m_starve = 0;
            else if (acc && g == 1) m_starve = 0;
            else if (acc && g == 2 && m_starve < STARV) m_starve++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        instruction_request = 0; instruction_address = '0; flush = 0;
        data_request = 0; data_wr = 0; data_address = '0; data_wdata = '0;
        data_be = '0; mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTb = 0;
        idle();
        instruction_request = 1;
        #3;
        chk("lit_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("lit_rst_perr", {31'd0, protocol_error}, 32'd0);
        cyc(); cyc();
        RSTb = 1; idle();

        // fetch stream 0x0/0x4/0x8, response one cycle after accept
        cyc(); instruction_request = 1; instruction_address = 32'h0;
        #2; chk("lit_f0_valid", {31'd0, mem_valid}, 32'd1);
            chk("lit_f0_be", {28'd0, mem_be}, 32'hF);
        cyc(); instruction_address = 32'h4; mem_rvalid = 1; mem_rdata = 32'h11110000;
        #2; chk("lit_f0_iv", {31'd0, instruction_valid}, 32'd1);
            chk("lit_f0_in", instruction_in, 32'h11110000);
        cyc(); instruction_address = 32'h8; mem_rdata = 32'h11110004;
        cyc(); instruction_request = 0; mem_rdata = 32'h11110008;
        #2; chk("lit_f8_in", instruction_in, 32'h11110008);

        // load vs fetch collision: data wins
        cyc(); idle(); instruction_request = 1; instruction_address = 32'hC;
        data_request = 1; data_address = 32'h1000;
        #2; chk("lit_ld_addr", mem_addr, 32'h1000);
        cyc(); data_request = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #2; chk("lit_ld_mrs", {31'd0, memory_request_successful}, 32'd1);
            chk("lit_ld_dv", {31'd0, data_rvalid}, 32'd1);
            chk("lit_ld_rdata", data_rdata, 32'hDEADBEEF);
            chk("lit_ld_fetch", mem_addr, 32'hC);
        cyc(); instruction_request = 0; mem_rdata = 32'h2222000C;
        cyc(); idle();

        // starvation: five stores with a fetch pending
        for (int i = 0; i < 5; i++) begin
            cyc(); instruction_request = 1; instruction_address = 32'h10;
            data_request = 1; data_wr = 1; data_address = 32'h2000 + 32'(4 * i);
            data_wdata = 32'hA0 + 32'(i); data_be = 4'hF;
            #2;
            if (i < 4) chk("lit_st_wr", {31'd0, mem_wr}, 32'd1);
            else       chk("lit_starve_fetch", mem_addr, 32'h10);
            if (i > 0) chk("lit_st_mrs", {31'd0, memory_request_successful}, 32'd1);
        end
        cyc(); idle(); mem_rvalid = 1; mem_rdata = 32'h33330010;
        #2; chk("lit_st5_mrs", {31'd0, memory_request_successful}, 32'd0);
            chk("lit_starve_iv", {31'd0, instruction_valid}, 32'd1);

        // flush with two fetches in flight
        cyc(); idle(); instruction_request = 1; instruction_address = 32'h20;
        cyc(); instruction_address = 32'h24;
        cyc(); idle(); flush = 1;
        cyc(); idle(); mem_rvalid = 1; mem_rdata = 32'hBAD00020;
        #2; chk("lit_kill0_iv", {31'd0, instruction_valid}, 32'd0);
        cyc(); mem_rdata = 32'hBAD00024;
        #2; chk("lit_kill1_iv", {31'd0, instruction_valid}, 32'd0);
        cyc(); idle(); instruction_request = 1; instruction_address = 32'h28;
        cyc(); idle(); mem_rvalid = 1; mem_rdata = 32'h44440028;
        #2; chk("lit_postflush_iv", {31'd0, instruction_valid}, 32'd1);

        // full FIFO blocks a load, even while a pop happens
        cyc(); idle(); instruction_request = 1; instruction_address = 32'h30;
        cyc(); instruction_address = 32'h34;
        cyc(); idle(); data_request = 1; data_address = 32'h1004;
        #2; chk("lit_full_mv", {31'd0, mem_valid}, 32'd0);
        cyc(); mem_rvalid = 1; mem_rdata = 32'h55550030;
        #2; chk("lit_fullpop_mv", {31'd0, mem_valid}, 32'd0);
            chk("lit_full_mrs", {31'd0, memory_request_successful}, 32'd0);
        cyc(); data_request = 0; mem_rdata = 32'h55550034;
        #2; chk("lit_full2_iv", {31'd0, instruction_valid}, 32'd1);

        // store after drain, then an orphan response
        cyc(); idle(); data_request = 1; data_wr = 1; data_address = 32'h2000;
        data_wdata = 32'hCAFEF00D; data_be = 4'h3;
        #2; chk("lit_st_be", {28'd0, mem_be}, 32'h3);
        cyc(); idle(); mem_rvalid = 1; mem_rdata = 32'h77777777;
        #2; chk("lit_orphan_dv", {31'd0, data_rvalid}, 32'd0);
        cyc(); idle();
        #2; chk("lit_perr_set", {31'd0, protocol_error}, 32'd1);
        cyc();
        #2; chk("lit_perr_hold", {31'd0, protocol_error}, 32'd1);

        // reset with one read outstanding
        cyc(); instruction_request = 1; instruction_address = 32'h40;
        cyc(); RSTb = 0;
        #2; chk("lit_rst2_perr", {31'd0, protocol_error}, 32'd0);
            chk("lit_rst2_mv", {31'd0, mem_valid}, 32'd0);
        cyc();
        cyc(); RSTb = 1; idle(); mem_rvalid = 1; mem_rdata = 32'h00000040;
        #2; chk("lit_rst2_iv", {31'd0, instruction_valid}, 32'd0);
        cyc(); idle(); instruction_request = 1; instruction_address = 32'h50;
        cyc(); idle(); mem_rvalid = 1; mem_rdata = 32'h66660050;
        #2; chk("lit_final_in", instruction_in, 32'h66660050);
            chk("lit_final_iv", {31'd0, instruction_valid}, 32'd1);
        cyc(); idle();
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_slurm32_mem_arbiter
`default_nettype wire
